rx_nrzi_decoder: RTL and testbench

Receive-path stage directly downstream of `cdr`: consumes the recovered line state `q` and its one-cycle `strobe`, and turns the low-speed (1.5 Mbit/s) J/K bit stream into bytes. Detects SYNC, performs NRZI decoding and bit unstuffing, assembles bytes LSB first, and detects EOP with stuff and alignment error reporting. Output feeds the packet layer (PID check, CRC).

---
 rtl/types.sv | 27 ++
 rtl/nrzi_unstuff.sv | 62 ++++++
 rtl/rx_nrzi_decoder.sv | 224 ++++++++++++++++++++++
 tb/tb_rx_nrzi_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/types.sv
// Shared receive-path types: line states from the CDR and the NRZI decoder FSM states.
package types;

    // {dp, dm} line state; low speed J is D- high.
    typedef enum logic [1:0] {
        LineSe0 = 2'b00,
        LineJ   = 2'b01,
        LineK   = 2'b10,
        LineSe1 = 2'b11
    } d_port_t;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
        StEop,
        StWaitIdle
    } rx_state_t;

    // Number of consecutive ones after which a zero is stuffed.
    localparam int unsigned STUFF_LEN = 6;

    function automatic logic is_jk(input d_port_t l);
        return (l == LineJ) || (l == LineK);
    endfunction

endpackage

// File: rtl/nrzi_unstuff.sv
// NRZI decode of the sampled line level plus ones-run tracking and stuff-bit removal.
module nrzi_unstuff
    import types::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    strobe,
    input  d_port_t d,
    input  logic    load,      // SYNC-terminating 1 seen: start the ones run at 1
    input  logic    data_en,   // decoded bits are packet data
    output logic    nrzi_bit,
    output logic    bit_valid,
    output logic    stuff_err
);

    d_port_t    prev_q;
    logic [2:0] ones_q;
    logic [2:0] ones_d;
    logic       jk;
    logic       stuff_slot;

    assign jk         = is_jk(d);
    assign nrzi_bit   = (d == prev_q);
    assign stuff_slot = (ones_q == 3'(STUFF_LEN));

    // Track the last J/K level; SE0/SE1 carry no NRZI information.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= LineJ;
        end else if (strobe && jk) begin
            prev_q <= d;
        end
    end

    // Ones-run update, stuff-bit drop and stuff violation detection.
    always_comb begin
        ones_d    = ones_q;
        bit_valid = 1'b0;
        stuff_err = 1'b0;
        if (strobe && load) begin
            ones_d = 3'd1;
        end else if (strobe && data_en && jk) begin
            if (stuff_slot) begin
                stuff_err = nrzi_bit;
                ones_d    = 3'd0;
            end else begin
                bit_valid = 1'b1;
                ones_d    = nrzi_bit ? ones_q + 3'd1 : 3'd0;
            end
        end
    end

    // Ones-run register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ones_q <= 3'd0;
        end else begin
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/rx_nrzi_decoder.sv
// Low-speed receive stage: SYNC detect, NRZI/unstuff, LSB-first byte assembly, EOP checking.
module rx_nrzi_decoder
    import types::*;
#(
    parameter int unsigned SYNC_MIN_ZEROS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  d_port_t    d,
    input  logic       strobe,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_eop,
    output logic       rx_error
);

    localparam logic [2:0] MinZeros = 3'(SYNC_MIN_ZEROS);

    rx_state_t  state_q, state_d;
    logic [2:0] zero_q, zero_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic [1:0] se0_cnt_q, se0_cnt_d;
    logic       from_sync_q, from_sync_d;
    logic [2:0] jcnt_q, jcnt_d;
    logic       se0_seen_q, se0_seen_d;
    logic       active_q, active_d;
    logic       valid_q, valid_d;
    logic       eop_q, eop_d;
    logic       err_q, err_d;

    logic       nrzi_bit;
    logic       bit_valid;
    logic       stuff_err;
    logic       sync_ok;
    logic       sync_done;

    assign sync_ok   = (zero_q >= MinZeros);
    assign sync_done = strobe && (state_q == StSync) && is_jk(d) && nrzi_bit && sync_ok;

    nrzi_unstuff u_unstuff (
        .clk       (clk),
        .reset     (reset),
        .strobe    (strobe),
        .d         (d),
        .load      (sync_done),
        .data_en   (state_q == StData),
        .nrzi_bit  (nrzi_bit),
        .bit_valid (bit_valid),
        .stuff_err (stuff_err)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, evaluated only on strobe cycles.
    always_comb begin
        state_d = state_q;
        if (strobe) begin
            unique case (state_q)
                StIdle: begin
                    if (d == LineK) state_d = StSync;
                end
                StSync: begin
                    if (d == LineSe0)      state_d = StEop;
                    else if (d == LineSe1) state_d = StWaitIdle;
                    else if (nrzi_bit)     state_d = sync_ok ? StData : StIdle;
                end
                StData: begin
                    if (d == LineSe0)                    state_d = StEop;
                    else if (d == LineSe1 || stuff_err)  state_d = StWaitIdle;
                end
                StEop: begin
                    case (d)
                        LineSe0: if (se0_cnt_q == 2'd2) state_d = StWaitIdle;
                        LineJ:   state_d = StIdle;
                        default: state_d = StWaitIdle;
                    endcase
                end
                StWaitIdle: begin
                    if (d == LineJ && (se0_seen_q || jcnt_q == 3'd7)) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Counters, byte assembly and next values of the registered outputs.
    always_comb begin
        zero_d      = zero_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        se0_cnt_d   = se0_cnt_q;
        from_sync_d = from_sync_q;
        jcnt_d      = jcnt_q;
        se0_seen_d  = se0_seen_q;
        valid_d     = 1'b0;
        eop_d       = 1'b0;
        err_d       = 1'b0;
        active_d    = (state_d == StData) || (state_d == StEop);
        if (strobe) begin
            unique case (state_q)
                StIdle: begin
                    if (d == LineK) begin
                        zero_d    = 3'd1;
                        bit_cnt_d = 3'd0;
                    end
                end
                StSync: begin
                    if (is_jk(d) && !nrzi_bit && zero_q != 3'd7) zero_d = zero_q + 3'd1;
                    if (sync_done) bit_cnt_d = 3'd0;
                    if (d == LineSe0) begin
                        se0_cnt_d   = 2'd1;
                        from_sync_d = 1'b1;
                    end
                    if (d == LineSe1) err_d = 1'b1;
                end
                StData: begin
                    if (bit_valid) begin
                        shift_d   = {nrzi_bit, shift_q[6:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d  = {nrzi_bit, shift_q};
                            valid_d = 1'b1;
                        end
                    end
                    if (d == LineSe0) begin
                        se0_cnt_d   = 2'd1;
                        from_sync_d = 1'b0;
                    end
                    if (d == LineSe1 || stuff_err) err_d = 1'b1;
                end
                StEop: begin
                    case (d)
                        LineSe0: begin
                            if (se0_cnt_q == 2'd2) err_d = 1'b1;
                            else se0_cnt_d = se0_cnt_q + 2'd1;
                        end
                        LineJ: begin
                            eop_d = 1'b1;
                            // Alignment: a partial byte or no data at all
                            err_d = (bit_cnt_q != 3'd0) || from_sync_q;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
                StWaitIdle: begin
                    case (d)
                        LineSe0: begin
                            se0_seen_d = 1'b1;
                            jcnt_d     = 3'd0;
                        end
                        LineJ: begin
                            se0_seen_d = 1'b0;
                            jcnt_d     = jcnt_q + 3'd1;
                        end
                        LineK: begin
                            se0_seen_d = 1'b0;
                            jcnt_d     = 3'd0;
                        end
                        default: begin
                            err_d      = 1'b1;
                            se0_seen_d = 1'b0;
                            jcnt_d     = 3'd0;
                        end
                    endcase
                end
                default: ;
            endcase
            // Fresh idle-hunt on every entry to WAIT_IDLE
            if (state_d == StWaitIdle && state_q != StWaitIdle) begin
                jcnt_d     = 3'd0;
                se0_seen_d = 1'b0;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_q      <= 3'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            data_q      <= 8'h00;
            se0_cnt_q   <= 2'd0;
            from_sync_q <= 1'b0;
            jcnt_q      <= 3'd0;
            se0_seen_q  <= 1'b0;
            active_q    <= 1'b0;
            valid_q     <= 1'b0;
            eop_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            zero_q      <= zero_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            se0_cnt_q   <= se0_cnt_d;
            from_sync_q <= from_sync_d;
            jcnt_q      <= jcnt_d;
            se0_seen_q  <= se0_seen_d;
            active_q    <= active_d;
            valid_q     <= valid_d;
            eop_q       <= eop_d;
            err_q       <= err_d;
        end
    end

    assign rx_active = active_q;
    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_eop    = eop_q;
    assign rx_error  = err_q;

endmodule

// File: tb/tb_rx_nrzi_decoder.sv
// Table-driven bench for rx_nrzi_decoder with an ordered scoreboard of output pulses.
module tb_rx_nrzi_decoder;
    import types::*;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       strobe = 1'b0;
    d_port_t    d      = LineJ;
    logic       rx_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_eop;
    logic       rx_error;

    int tests = 0;
    int fails = 0;

    // Expected pulse records: {valid, eop, error, data (only meaningful with valid)}
    logic [10:0] exp_q[$];
    localparam logic [10:0] EvEop    = 11'h200;
    localparam logic [10:0] EvErr    = 11'h100;
    localparam logic [10:0] EvEopErr = 11'h300;
    localparam logic [10:0] EvNone   = 11'h000;

    typedef struct {
        string       name;
        int          gap;         // clk cycles between strobes (cdr phase variants)
        int          sync_zeros;  // decoded zeros before the SYNC-final 1
        int          nbits;
        logic [15:0] bits;        // LSB sent first
        bit          stuff;       // transmitter inserts stuff bits
        string       tail;        // raw line symbols: 0=SE0 1=SE1 J K
        int          nev;
        logic [10:0] ev0, ev1, ev2;
    } vec_t;

    vec_t vecs [11];

    d_port_t lvl;
    int      ones;

    rx_nrzi_decoder #(.SYNC_MIN_ZEROS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .d         (d),
        .strobe    (strobe),
        .rx_active (rx_active),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_eop    (rx_eop),
        .rx_error  (rx_error)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] ev_byte(input logic [7:0] b);
        return {3'b100, b};
    endfunction

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endfunction

    function automatic d_port_t sym_of(input byte c);
        if (c == "0") return LineSe0;
        if (c == "1") return LineSe1;
        if (c == "K") return LineK;
        return LineJ;
    endfunction

    // One clk: sample outputs at negedge, score any pulse, return to posedge+1.
    task automatic tick();
        logic [10:0] obs;
        @(negedge clk);
        if (rx_valid || rx_eop || rx_error) begin
            obs = {rx_valid, rx_eop, rx_error, rx_valid ? rx_data : 8'h00};
            if (exp_q.size() == 0) check("unexpected pulse", 32'(obs), 32'(EvNone));
            else check("pulse", 32'(obs), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_sym(input d_port_t s, input int gap);
        d      = s;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        repeat (gap - 1) tick();
    endtask

    // NRZI-encode one bit, inserting a stuff zero after six ones when enabled.
    task automatic send_bit(input logic b, input int gap, input bit stuff);
        if (!b) lvl = (lvl == LineJ) ? LineK : LineJ;
        strobe_sym(lvl, gap);
        if (stuff) begin
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
                lvl  = (lvl == LineJ) ? LineK : LineJ;
                strobe_sym(lvl, gap);
                ones = 0;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        lvl  = LineJ;
        ones = 0;
        if (v.nev > 0) exp_q.push_back(v.ev0);
        if (v.nev > 1) exp_q.push_back(v.ev1);
        if (v.nev > 2) exp_q.push_back(v.ev2);
        for (int i = 0; i < v.sync_zeros; i++) send_bit(1'b0, v.gap, v.stuff);
        send_bit(1'b1, v.gap, v.stuff);
        check({v.name, " active after sync"}, 32'(rx_active), 32'(v.sync_zeros >= 3));
        for (int i = 0; i < v.nbits; i++) send_bit(v.bits[i], v.gap, v.stuff);
        for (int i = 0; i < v.tail.len(); i++) strobe_sym(sym_of(v.tail[i]), v.gap);
        for (int i = 0; i < 10; i++) strobe_sym(LineJ, v.gap);
        check({v.name, " pulses outstanding"}, 32'(exp_q.size()), 32'd0);
        check({v.name, " active at idle"}, 32'(rx_active), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        vecs[0]  = '{"a5",        16, 7, 8,  16'h00A5, 1'b1, "00J",  2,
                     ev_byte(8'hA5), EvEop, EvNone};
        vecs[1]  = '{"ff00",      16, 7, 16, 16'h00FF, 1'b1, "00J",  3,
                     ev_byte(8'hFF), ev_byte(8'h00), EvEop};
        vecs[2]  = '{"stuff err", 17, 7, 7,  16'h007F, 1'b0, "0J",   1,
                     EvErr, EvNone, EvNone};
        vecs[3]  = '{"align",     15, 7, 3,  16'h0005, 1'b1, "00J",  1,
                     EvEopErr, EvNone, EvNone};
        vecs[4]  = '{"se0 x3",    16, 7, 8,  16'h00A5, 1'b1, "000",  2,
                     ev_byte(8'hA5), EvErr, EvNone};
        vecs[5]  = '{"sync3 p<0", 15, 3, 8,  16'h003C, 1'b1, "00J",  2,
                     ev_byte(8'h3C), EvEop, EvNone};
        vecs[6]  = '{"sync3 p=0", 16, 3, 8,  16'h003C, 1'b1, "00J",  2,
                     ev_byte(8'h3C), EvEop, EvNone};
        vecs[7]  = '{"sync3 p>0", 17, 3, 8,  16'h003C, 1'b1, "00J",  2,
                     ev_byte(8'h3C), EvEop, EvNone};
        vecs[8]  = '{"sync2 p<0", 15, 2, 0,  16'h0000, 1'b1, "",     0,
                     EvNone, EvNone, EvNone};
        vecs[9]  = '{"sync2 p=0", 16, 2, 0,  16'h0000, 1'b1, "",     0,
                     EvNone, EvNone, EvNone};
        vecs[10] = '{"sync2 p>0", 17, 2, 0,  16'h0000, 1'b1, "",     0,
                     EvNone, EvNone, EvNone};

        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs",
              32'({rx_active, rx_valid, rx_eop, rx_error, rx_data}), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) strobe_sym(LineJ, 16);
        check("idle outputs",
              32'({rx_active, rx_valid, rx_eop, rx_error, rx_data}), 32'd0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Reset mid-packet: outputs clear at once, then a fresh packet decodes.
        lvl  = LineJ;
        ones = 0;
        for (int i = 0; i < 7; i++) send_bit(1'b0, 16, 1'b1);
        send_bit(1'b1, 16, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'(i), 16, 1'b1);
        check("active before mid reset", 32'(rx_active), 32'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async reset outputs",
              32'({rx_active, rx_valid, rx_eop, rx_error, rx_data}), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) strobe_sym(LineJ, 16);
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
